fp_addsub_seq: RTL and testbench

//  Multi-cycle IEEE-754 binary32 add/subtract unit with valid/ready handshakes on both sides.
//  It accepts an (A, B, op) request from a producer and returns one rounded result to a consumer.
//  It computes A+B or A-B in a fixed 4-stage FSM and supports back-pressure.
//  It sits between a request source (host/bench/sequencer) and the result sink of the FP datapath.

---
 rtl/fp_addsub_seq.sv | 178 +++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE, truncating rounding.
// Denormal inputs and underflowing results are flushed to signed zero.
module fp_addsub_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [EXP_W+FRAC_W:0]     i_op_a,
    input  logic [EXP_W+FRAC_W:0]     i_op_b,
    input  logic                      i_op_sub,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [EXP_W+FRAC_W:0]     o_result,
    output logic                      o_flag_ovf,
    output logic                      o_flag_inv
);
    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int MW  = FRAC_W + 4;
    localparam int LZW = $clog2(MW);
    localparam logic [EXP_W-1:0]   EMAX  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]   SHMAX = EXP_W'(MW - 1);
    localparam logic [EXP_W+1:0]   EMAXW = {2'b00, EMAX};
    localparam logic [W-1:0]       QNAN  = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [W-1:0]       r_opA, r_opB;
    logic               r_sub;
    logic [MW-1:0]      r_mantL, r_mantS;
    logic [EXP_W-1:0]   r_expL;
    logic               r_signL, r_effSub;
    logic               r_spec, r_specInv;
    logic [W-1:0]       r_specRes;
    logic [MW:0]        r_sum;
    logic [W-1:0]       r_result;
    logic               r_ovf, r_inv;

    logic               w_signA, w_signB, w_nanA, w_nanB, w_infA, w_infB;
    logic [EXP_W-1:0]   w_expA, w_expB, w_expL, w_expS, w_diff;
    logic [W-2:0]       w_magA, w_magB, w_magL, w_magS;
    logic               w_swap, w_signL;
    logic [MW-1:0]      w_mantL, w_mantS, w_alignS;
    logic               w_specInv;
    logic [W-1:0]       w_specRes;

    logic [LZW-1:0]     w_lzc;
    logic [MW-1:0]      w_normMant;
    logic [EXP_W+1:0]   w_expN;
    logic [FRAC_W-1:0]  w_fracN;
    logic [W-1:0]       w_normRes;
    logic               w_normOvf, w_normInv;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_nextState = ALIGN;
            ALIGN:   w_nextState = ADD;
            ADD:     w_nextState = NORM;
            NORM:    w_nextState = DONE;
            DONE:    if (i_out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == IDLE);
        o_out_valid = (r_state == DONE);
        o_result    = r_result;
        o_flag_ovf  = r_ovf;
        o_flag_inv  = r_inv;
    end

    // Unpack, flush denormals, order by magnitude and align the smaller operand with sticky.
    always_comb begin
        w_signA = r_opA[W-1];
        w_signB = r_opB[W-1] ^ r_sub;
        w_expA  = r_opA[W-2:FRAC_W];
        w_expB  = r_opB[W-2:FRAC_W];
        w_nanA  = (w_expA == EMAX) && (r_opA[FRAC_W-1:0] != '0);
        w_nanB  = (w_expB == EMAX) && (r_opB[FRAC_W-1:0] != '0);
        w_infA  = (w_expA == EMAX) && (r_opA[FRAC_W-1:0] == '0);
        w_infB  = (w_expB == EMAX) && (r_opB[FRAC_W-1:0] == '0);
        w_magA  = (w_expA == '0) ? '0 : r_opA[W-2:0];
        w_magB  = (w_expB == '0) ? '0 : r_opB[W-2:0];
        w_swap  = (w_magB > w_magA);
        w_magL  = w_swap ? w_magB : w_magA;
        w_magS  = w_swap ? w_magA : w_magB;
        w_signL = w_swap ? w_signB : w_signA;
        w_expL  = w_magL[W-2:FRAC_W];
        w_expS  = w_magS[W-2:FRAC_W];
        w_mantL = {(w_expL != '0), w_magL[FRAC_W-1:0], 3'b000};
        w_mantS = {(w_expS != '0), w_magS[FRAC_W-1:0], 3'b000};
        w_diff  = w_expL - w_expS;
        if (w_diff >= SHMAX)
            w_alignS = {{(MW-1){1'b0}}, (w_mantS != '0)};
        else
            w_alignS = (w_mantS >> w_diff)
                     | {{(MW-1){1'b0}}, |(w_mantS & ~({MW{1'b1}} << w_diff))};
        w_specInv = w_nanA | w_nanB | (w_infA & w_infB & (w_signA != w_signB));
        if (w_specInv)   w_specRes = QNAN;
        else if (w_infA) w_specRes = {w_signA, EMAX, {FRAC_W{1'b0}}};
        else             w_specRes = {w_signB, EMAX, {FRAC_W{1'b0}}};
    end

    // Normalise the raw sum: carry shifts right, otherwise leading zeros shift left.
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < MW; i++)
            if (r_sum[i]) w_lzc = LZW'(MW - 1 - i);
        w_normMant = r_sum[MW-1:0] << w_lzc;
        if (r_sum[MW]) begin
            w_expN  = {2'b00, r_expL} + 1'b1;
            w_fracN = r_sum[MW-1:4];
        end else begin
            w_expN  = {2'b00, r_expL} - {{(EXP_W+2-LZW){1'b0}}, w_lzc};
            w_fracN = w_normMant[MW-2:3];
        end
        w_normOvf = 1'b0;
        w_normInv = 1'b0;
        if (r_spec) begin
            w_normRes = r_specRes;
            w_normInv = r_specInv;
        end else if (r_sum == '0)
            w_normRes = {r_signL & ~r_effSub, {(W-1){1'b0}}};
        else if (w_expN[EXP_W+1] || (w_expN == '0))
            w_normRes = {r_signL, {(W-1){1'b0}}};
        else if (w_expN >= EMAXW) begin
            w_normRes = {r_signL, EMAX, {FRAC_W{1'b0}}};
            w_normOvf = 1'b1;
        end else
            w_normRes = {r_signL, w_expN[EXP_W-1:0], w_fracN};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_opA <= i_op_a;
                    r_opB <= i_op_b;
                    r_sub <= i_op_sub;
                end
                ALIGN: begin
                    r_mantL   <= w_mantL;
                    r_mantS   <= w_alignS;
                    r_expL    <= w_expL;
                    r_signL   <= w_signL;
                    r_effSub  <= w_signA ^ w_signB;
                    r_spec    <= w_nanA | w_nanB | w_infA | w_infB;
                    r_specInv <= w_specInv;
                    r_specRes <= w_specRes;
                end
                ADD: r_sum <= r_effSub ? ({1'b0, r_mantL} - {1'b0, r_mantS})
                                       : ({1'b0, r_mantL} + {1'b0, r_mantS});
                NORM: begin
                    r_result <= w_normRes;
                    r_ovf    <= w_normOvf;
                    r_inv    <= w_normInv;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed binary32 vectors, back-pressure and mid-op reset.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst, inValid, inReady, opSub, outValid, outReady, flagOvf, flagInv;
    logic [31:0] opA, opB, result;
    int          numChecks = 0;
    int          numFails  = 0;

    fp_addsub_seq dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(inValid), .o_in_ready(inReady),
        .i_op_a(opA), .i_op_b(opB), .i_op_sub(opSub), .o_out_valid(outValid),
        .i_out_ready(outReady), .o_result(result), .o_flag_ovf(flagOvf), .o_flag_inv(flagInv)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid is seen; bounded.
    task automatic waitValid(output int k);
        k = 1;
        while (outValid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic [31:0] expRes,
                                 input logic expOvf, input logic expInv);
        int k;
        @(negedge clk);
        checkOutput({tag, " in_ready"}, 64'(inReady), 64'd1);
        opA = a; opB = b; opSub = sub; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        waitValid(k);
        checkOutput({tag, " latency"}, 64'(k), 64'd4);
        checkOutput({tag, " result"}, 64'({inReady, result}), 64'({1'b0, expRes}));
        checkOutput({tag, " flags"}, 64'({flagOvf, flagInv}), 64'({expOvf, expInv}));
        @(posedge clk); #1;
        checkOutput({tag, " release"}, 64'({outValid, inReady}), 64'b01);
    endtask

    initial begin
        int  k;
        logic sawValid;
        rst = 1'b1; inValid = 1'b0; opA = '0; opB = '0; opSub = 1'b0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 64'({outValid, inReady, flagOvf, flagInv, result}),
                    64'({1'b0, 1'b1, 1'b0, 1'b0, 32'h0}));
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("1+2",       32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        applyStimulus("1-1",       32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("1-2^-24",   32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0);
        applyStimulus("1-2^-25",   32'h3F800000, 32'h33000000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0);
        applyStimulus("1+2^-24",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        applyStimulus("inf+-inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
        applyStimulus("inf-inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        applyStimulus("max+max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        applyStimulus("-inf+-inf", 32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
        applyStimulus("1--inf",    32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0);
        applyStimulus("nan+1",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
        applyStimulus("denorm",    32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        applyStimulus("-2+1",      32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0);

        // Back-pressure: result must hold while the consumer stalls; requests are ignored.
        @(negedge clk);
        opA = 32'h3F800000; opB = 32'h40000000; opSub = 1'b0; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        waitValid(k);
        checkOutput("bp latency", 64'(k), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inValid = (i % 2 == 0);
            opA = 32'h7FC00000;
            @(posedge clk); #1;
            checkOutput($sformatf("bp hold %0d", i),
                        64'({outValid, inReady, flagOvf, flagInv, result}),
                        64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h40400000}));
        end
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp release", 64'({outValid, inReady}), 64'b01);

        // Reset while the op sits in NORM: nothing may come out afterwards.
        @(negedge clk);
        opA = 32'h40400000; opB = 32'h3F800000; opSub = 1'b1; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst state", 64'({outValid, inReady}), 64'b01);
        sawValid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            sawValid = sawValid | outValid;
        end
        checkOutput("midrst no stale", 64'(sawValid), 64'd0);
        applyStimulus("3-1 post-reset", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
